hcsr04_emulator: RTL

HCSR04_EMULATOR -- requirements
Module: hcsr04_emulator

---
 rtl/hcsr04_emulator.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hcsr04_emulator.sv
// HC-SR04 ultrasonic ranger emulator.
// Watches a trigger pulse from the initiator and answers with an echo pulse.
// The echo width is proportional to dist_cm. Distances outside [MIN_CM, MAX_CM]
// get the no-object width TIMEOUT_CYC instead.
// Optional feature: defining HCSR04_EMU_JITTER_EN adds 0-63 cycles of LFSR jitter
// to every echo width.
module hcsr04_emulator #(
  parameter int unsigned CYC_PER_CM   = 1566,
  parameter int unsigned TRIG_MIN_CYC = 270,
  parameter int unsigned BURST_CYC    = 5400,
  parameter int unsigned TIMEOUT_CYC  = 1026000,
  parameter int unsigned HOLDOFF_CYC  = 27000,
  parameter int unsigned MIN_CM       = 2,
  parameter int unsigned MAX_CM       = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] dist_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_short,
  output logic       trig_ignored
);

  typedef enum logic [2:0] {StIdle, StTrigHi, StBurst, StEcho, StHoldoff} state_e;

  state_e      state_q, state_d;
  logic [2:0]  trig_pipe_q, trig_pipe_d;  // [0],[1]: synchronizer; [2]: edge-detect delay
  logic [20:0] cnt_q, cnt_d;
  logic [20:0] width_q, width_d;
  logic        echo_q, echo_d;
  logic        short_q, short_d;
  logic        ign_q, ign_d;

  logic        trig_rise, trig_fall;
  logic        dist_in_range;
  logic [20:0] dist_width, base_width, sample_width;

`ifdef HCSR04_EMU_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois LFSR, taps 16,14,13,11, free-running every cycle
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // LFSR register, reseeded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  // Trigger synchronizer and edge detection
  always_comb begin
    trig_pipe_d = {trig_pipe_q[1:0], trig};
    trig_rise   = trig_pipe_q[1] & ~trig_pipe_q[2];
    trig_fall   = ~trig_pipe_q[1] & trig_pipe_q[2];
  end

  // Echo width for the current dist_cm; it is captured only on a valid trigger fall
  always_comb begin
    dist_width    = 21'(dist_cm) * 21'(CYC_PER_CM);
    dist_in_range = (dist_cm >= 9'(MIN_CM)) && (dist_cm <= 9'(MAX_CM));
    base_width    = dist_in_range ? dist_width : 21'(TIMEOUT_CYC);
`ifdef HCSR04_EMU_JITTER_EN
    sample_width  = base_width + {15'd0, lfsr_q[5:0]};
`else
    sample_width  = base_width;
`endif
  end

  // Measurement sequencer: next state, counters and output pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    echo_d  = 1'b0;
    short_d = 1'b0;
    ign_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig_rise) begin
          state_d = StTrigHi;
          cnt_d   = '0;
        end
      end
      StTrigHi: begin
        // The rise-detect cycle is part of the high time, hence the -1
        if (trig_fall) begin
          if (cnt_q >= 21'(TRIG_MIN_CYC - 1)) begin
            width_d = sample_width;
            state_d = StBurst;
            cnt_d   = '0;
          end else begin
            short_d = 1'b1;
            state_d = StIdle;
          end
        end else if (cnt_q < 21'(TRIG_MIN_CYC)) begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      StBurst: begin
        ign_d = trig_rise;
        // echo is registered, so it is raised one count early
        if (cnt_q == 21'(BURST_CYC - 2)) begin
          state_d = StEcho;
          cnt_d   = '0;
          echo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      StEcho: begin
        ign_d = trig_rise;
        if (cnt_q == width_q - 21'd1) begin
          state_d = StHoldoff;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + 21'd1;
          echo_d = 1'b1;
        end
      end
      StHoldoff: begin
        ign_d = trig_rise;
        if (cnt_q == 21'(HOLDOFF_CYC - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      trig_pipe_q <= '0;
      cnt_q       <= '0;
      width_q     <= '0;
      echo_q      <= 1'b0;
      short_q     <= 1'b0;
      ign_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_pipe_q <= trig_pipe_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      echo_q      <= echo_d;
      short_q     <= short_d;
      ign_q       <= ign_d;
    end
  end

  assign echo         = echo_q;
  assign busy         = (state_q != StIdle);
  assign trig_short   = short_q;
  assign trig_ignored = ign_q;

endmodule
